sio_cmd_sched: RTL and testbench

Host-side command scheduler for the remote serial IO link. Arbitrates N requesters (register writes, ADC SPI configuration, sync control) onto the single 20-bit command slot that the host serializer transmits once per 128-clock frame. Routes the 16-bit readback word returned later in the same frame to the requester that owns the command. Sits between the host's local register and sequencing logic and the sdio serializer/deserializer pair.

---
 rtl/sio_cmd_sched.sv | 130 +++++++++++++
 tb/tb_sio_cmd_sched.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sio_cmd_sched.sv
// Host-side command scheduler: round-robin grant of one 20-bit command per link frame,
// and routing of the in-frame readback word (or a timeout) back to the owning requester.
module sio_cmd_sched #(
    parameter int N_REQ     = 4,
    parameter int FRAME_LEN = 128
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [4*N_REQ-1:0]    req_addr,
    input  logic [16*N_REQ-1:0]   req_wdata,
    output logic [N_REQ-1:0]      req_ready,
    output logic                  frame_start,
    output logic                  cmd_valid,
    output logic [19:0]           cmd,
    input  logic                  rx_rdata_valid,
    input  logic [15:0]           rx_rdata,
    output logic                  rsp_valid,
    output logic [2:0]            rsp_id,
    output logic [15:0]           rsp_data,
    output logic                  rsp_timeout,
    output logic [7:0]            err_count
);

    localparam int CW = $clog2(FRAME_LEN);
    localparam int IW = $clog2(N_REQ);

    logic [CW-1:0] cnt;
    logic [IW-1:0] ptr;
    logic [IW-1:0] owner;
    logic [IW-1:0] win;
    logic [IW-1:0] idx;
    logic [3:0]    sel_addr;
    logic [15:0]   sel_wdata;
    logic          answered;
    logic          found;
    logic          arb;
    logic          grant;
    logic          rx_ok;
    logic          tmo;
    logic          err_inc;

    assign arb = (cnt == CW'(FRAME_LEN - 1));

    // Round-robin search starting at ptr; first valid requester wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = IW'((int'(ptr) + k) % N_REQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign grant = arb && enable && found;

    always_comb begin
        req_ready = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (IW'(k) == win) begin
                req_ready[k] = grant && !reset;
                sel_addr     = req_addr[4*k +: 4];
                sel_wdata    = req_wdata[16*k +: 16];
            end
        end
    end

    // A readback arriving on the arbitration edge still counts for the outgoing frame.
    assign rx_ok   = rx_rdata_valid && cmd_valid && !answered;
    assign tmo     = arb && cmd_valid && !answered && !rx_rdata_valid;
    assign err_inc = (rx_rdata_valid && !rx_ok) || tmo;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt         <= CW'(FRAME_LEN - 1);
            ptr         <= '0;
            owner       <= '0;
            answered    <= 1'b1;
            cmd         <= '0;
            cmd_valid   <= 1'b0;
            frame_start <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_data    <= '0;
            rsp_timeout <= 1'b0;
            err_count   <= '0;
        end else begin
            cnt         <= arb ? '0 : cnt + 1'b1;
            frame_start <= arb;
            rsp_valid   <= 1'b0;

            if (rx_ok) begin
                rsp_valid   <= 1'b1;
                rsp_id      <= 3'(owner);
                rsp_data    <= rx_rdata;
                rsp_timeout <= 1'b0;
                answered    <= 1'b1;
            end else if (tmo) begin
                rsp_valid   <= 1'b1;
                rsp_id      <= 3'(owner);
                rsp_data    <= '0;
                rsp_timeout <= 1'b1;
            end

            if (err_inc && err_count != 8'hFF)
                err_count <= err_count + 1'b1;

            // Grant overrides the answered flag set by a same-edge readback.
            if (arb) begin
                if (grant) begin
                    cmd       <= {sel_addr, sel_wdata};
                    cmd_valid <= 1'b1;
                    owner     <= win;
                    ptr       <= (win == IW'(N_REQ - 1)) ? '0 : win + 1'b1;
                    answered  <= 1'b0;
                end else begin
                    cmd_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_sio_cmd_sched.sv
// Directed bench for sio_cmd_sched: expected responses are queued at grant time
// and checked by an independent monitor against the observed rsp pulses.
module tb_sio_cmd_sched;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [15:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [3:0]  req_ready;
    logic        frame_start;
    logic        cmd_valid;
    logic [19:0] cmd;
    logic        rx_rdata_valid = 1'b0;
    logic [15:0] rx_rdata = '0;
    logic        rsp_valid;
    logic [2:0]  rsp_id;
    logic [15:0] rsp_data;
    logic        rsp_timeout;
    logic [7:0]  err_count;

    sio_cmd_sched #(.N_REQ(4), .FRAME_LEN(128)) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .req_valid(req_valid), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .frame_start(frame_start), .cmd_valid(cmd_valid),
        .cmd(cmd), .rx_rdata_valid(rx_rdata_valid), .rx_rdata(rx_rdata),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_timeout(rsp_timeout), .err_count(err_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        int id;
        int data;
        int to;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   tb_cnt = 127;
    int   tb_cyc = 0;

    // Reference frame position and cycle count.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            tb_cnt <= 127;
        end else begin
            tb_cnt <= (tb_cnt == 127) ? 0 : tb_cnt + 1;
            tb_cyc <= tb_cyc + 1;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", name, act, exp, tb_cyc);
        end
    endtask

    // Monitor: pop and compare on every rsp pulse; flag responses that never came.
    always @(negedge clock) begin
        if (!reset) begin
            if (q.size() > 0 && tb_cyc > q[0].cyc) begin
                checks++;
                errors++;
                $display("FAIL rsp_missing: got none expected id %0d at cyc %0d", q[0].id, q[0].cyc);
                void'(q.pop_front());
            end
            if (rsp_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got id %0d data 0x%0h expected no rsp", rsp_id, rsp_data);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("rsp_cyc", tb_cyc, e.cyc);
                    check("rsp_id", int'(rsp_id), e.id);
                    check("rsp_data", int'(rsp_data), e.data);
                    check("rsp_timeout", int'(rsp_timeout), e.to);
                end
            end
        end
    end

    task automatic go_to(input int c);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (tb_cnt != c && n < 400);
        if (tb_cnt != c) begin
            checks++;
            errors++;
            $display("FAIL go_to: got cnt %0d expected %0d", tb_cnt, c);
        end
    endtask

    task automatic pulse_rx(input logic [15:0] d);
        rx_rdata_valid = 1'b1;
        rx_rdata       = d;
        @(negedge clock);
        rx_rdata_valid = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ready"}, int'(req_ready), 0);
        check({tag, "_frame_start"}, int'(frame_start), 0);
        check({tag, "_cmd_valid"}, int'(cmd_valid), 0);
        check({tag, "_cmd"}, int'(cmd), 0);
        check({tag, "_rsp_valid"}, int'(rsp_valid), 0);
        check({tag, "_rsp_id"}, int'(rsp_id), 0);
        check({tag, "_rsp_data"}, int'(rsp_data), 0);
        check({tag, "_rsp_timeout"}, int'(rsp_timeout), 0);
        check({tag, "_err"}, int'(err_count), 0);
    endtask

    initial begin
        // Reset with requests pending: ready must stay low.
        req_valid = 4'b1111;
        repeat (3) @(negedge clock);
        check_idle_outputs("reset");

        // Single request from requester 2.
        req_valid        = 4'b0100;
        req_addr[11:8]   = 4'h3;
        req_wdata[47:32] = 16'h1234;
        reset = 1'b0;
        #1;
        check("single_ready", int'(req_ready), 4'b0100);
        q.push_back('{2, 16'h00A5, 0, tb_cyc + 110});
        @(negedge clock);
        check("single_frame_start", int'(frame_start), 1);
        check("single_cmd", int'(cmd), 20'h31234);
        check("single_cmd_valid", int'(cmd_valid), 1);
        req_valid = 4'b0000;
        go_to(108);
        pulse_rx(16'h00A5);

        // Timeout: requester 1 granted, no readback.
        go_to(127);
        req_valid        = 4'b0010;
        req_addr[7:4]    = 4'h5;
        req_wdata[31:16] = 16'hBEEF;
        #1;
        check("tmo_ready", int'(req_ready), 4'b0010);
        q.push_back('{1, 0, 1, tb_cyc + 129});
        @(negedge clock);
        check("tmo_cmd", int'(cmd), 20'h5BEEF);
        req_valid = 4'b0000;
        go_to(127);
        #1;
        check("tmo_no_ready", int'(req_ready), 0);
        @(negedge clock);
        check("tmo_err", int'(err_count), 1);
        check("tmo_cmd_valid", int'(cmd_valid), 0);

        // Readback coincident with the arbitration edge, then a stray readback.
        go_to(127);
        req_valid        = 4'b1000;
        req_addr[15:12]  = 4'hA;
        req_wdata[63:48] = 16'h5555;
        #1;
        check("edge_ready", int'(req_ready), 4'b1000);
        q.push_back('{3, 16'h5A5A, 0, tb_cyc + 129});
        @(negedge clock);
        check("edge_cmd", int'(cmd), 20'hA5555);
        req_valid = 4'b0000;
        go_to(127);
        pulse_rx(16'h5A5A);
        check("edge_cmd_valid", int'(cmd_valid), 0);
        check("edge_err", int'(err_count), 1);
        go_to(50);
        pulse_rx(16'hDEAD);
        check("stray_err", int'(err_count), 2);

        // Round robin across 8 frames with all requesters valid.
        go_to(127);
        req_valid = 4'b1111;
        for (int f = 0; f < 8; f++) begin
            if (f > 0) go_to(127);
            #1;
            check("rr_ready", int'(req_ready), 1 << (f % 4));
            q.push_back('{f % 4, 16'h1000 + f, 0, tb_cyc + 62});
            @(negedge clock);
            if (f == 7) req_valid = 4'b0000;
            go_to(60);
            pulse_rx(16'(16'h1000 + f));
        end
        check("rr_err", int'(err_count), 2);

        // enable=0 across an arbitration edge.
        enable    = 1'b0;
        req_valid = 4'b1111;
        go_to(127);
        #1;
        check("en_ready", int'(req_ready), 0);
        @(negedge clock);
        check("en_cmd_valid", int'(cmd_valid), 0);
        check("en_frame_start", int'(frame_start), 1);

        // Reset in the middle of a commanded frame discards the command.
        enable          = 1'b1;
        req_valid       = 4'b0001;
        req_addr[3:0]   = 4'h7;
        req_wdata[15:0] = 16'h0F0F;
        go_to(127);
        #1;
        check("rst_grant_ready", int'(req_ready), 4'b0001);
        @(negedge clock);
        check("rst_grant_cmd", int'(cmd), 20'h70F0F);
        go_to(40);
        reset = 1'b1;
        #1;
        check_idle_outputs("midreset");
        repeat (2) @(negedge clock);
        req_valid = 4'b0000;
        reset = 1'b0;
        #1;
        check("rel_frame_start0", int'(frame_start), 0);
        @(negedge clock);
        check("rel_frame_start1", int'(frame_start), 1);
        check("rel_cmd_valid", int'(cmd_valid), 0);
        repeat (260) @(negedge clock);
        check("final_err", int'(err_count), 0);
        check("final_queue_empty", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

endmodule
